// File: rtl/cadd_share_arbiter_pkg.sv
// Shared definitions for the complex-add share arbiter.
//   CW        : complex word width {real, imag}
//   LW        : lane width (real and imag are independent LW-bit lanes)
//   RE_LSB    : bit position of the real lane within a complex word
//   IM_LSB    : bit position of the imag lane within a complex word
//   CNT_W     : per-requester grant counter width
//   state_e   : result-slot state (EMPTY / FULL)
package cadd_share_arbiter_pkg;

  localparam int CW     = 32;
  localparam int LW     = 16;
  localparam int RE_LSB = 16;
  localparam int IM_LSB = 0;
  localparam int CNT_W  = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/cadd_share_arbiter_ksa.sv
// 32-bit complex adder built from two independent 16-bit Kogge-Stone lanes.
// Each lane adds modulo 2^16 with carry-in 0; there is no carry between lanes.
// Ports:
//   a_i, b_i [CW-1:0] : operands {real, imag}
//   sum_o    [CW-1:0] : lane-wise sum {real, imag}
//   cout_o   [1:0]    : {real carry, imag carry}
module cadd_share_arbiter_ksa
  import cadd_share_arbiter_pkg::*;
(
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  output logic [CW-1:0] sum_o,
  output logic [1:0]    cout_o
);

  localparam int NLVL = $clog2(LW);

  // Lane 0 sits at IM_LSB, lane 1 at RE_LSB, so cout_o[l] lines up with
  // the {real, imag} ordering of the carry output.
  for (genvar l = 0; l < 2; l++) begin : g_lane
    localparam int LSB = (l == 0) ? IM_LSB : RE_LSB;

    logic [NLVL:0][LW-1:0] g, p;
    logic                  unused_p;

    assign g[0] = a_i[LSB +: LW] & b_i[LSB +: LW];
    assign p[0] = a_i[LSB +: LW] ^ b_i[LSB +: LW];

    // Prefix tree: after level k, g[k][i] is the group generate of bits
    // [i : max(0, i-2^k+1)]. Bits below the span are already complete.
    for (genvar k = 0; k < NLVL; k++) begin : g_lvl
      localparam int D = 1 << k;
      for (genvar i = 0; i < LW; i++) begin : g_bit
        if (i >= D) begin : g_op
          assign g[k+1][i] = g[k][i] | (p[k][i] & g[k][i-D]);
          assign p[k+1][i] = p[k][i] & p[k][i-D];
        end else begin : g_pass
          assign g[k+1][i] = g[k][i];
          assign p[k+1][i] = p[k][i];
        end
      end
    end

    // Final-level propagate is not needed by the sum; keep it visibly sunk.
    assign unused_p = ^p[NLVL];

    assign sum_o[LSB +: LW] = p[0] ^ {g[NLVL][LW-2:0], 1'b0};
    assign cout_o[l]        = g[NLVL][LW-1];
  end

endmodule

// File: rtl/cadd_share_arbiter.sv
// Round-robin arbiter sharing one complex adder between NREQ requesters,
// with a single-entry result slot (1 result/cycle when downstream is ready).
// Optional feature: define CADD_ARB_GNT_CNT_EN for per-requester 16-bit
// grant counters; otherwise gnt_cnt_o is tied to zero and no flops exist.
// Ports:
//   clk_i, rst_ni        : clock, async active-low reset
//   req_valid_i [NREQ]   : per-requester operand valid
//   req_a_i, req_b_i     : packed operands, slice i = [32i+31:32i]
//   req_ready_o [NREQ]   : one-hot grant (combinational)
//   rsp_valid_o/ready_i  : result handshake
//   rsp_data_o  [32]     : complex sum {real, imag}
//   rsp_cout_o  [2]      : {real carry, imag carry}
//   rsp_id_o    [IDW]    : requester that produced the result
//   gnt_cnt_o   [NREQ*16]: grant counters, slice i = [16i+15:16i]
module cadd_share_arbiter
  import cadd_share_arbiter_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*CW-1:0]    req_a_i,
  input  logic [NREQ*CW-1:0]    req_b_i,
  output logic [NREQ-1:0]       req_ready_o,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [CW-1:0]         rsp_data_o,
  output logic [1:0]            rsp_cout_o,
  output logic [IDW-1:0]        rsp_id_o,
  output logic [NREQ*CNT_W-1:0] gnt_cnt_o
);

  state_e         state_q, state_d;
  logic [IDW-1:0] last_q;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] cand;
  logic           win_found;
  logic           slot_free;
  logic           accept;
  logic [CW-1:0]  op_a, op_b, sum;
  logic [1:0]     cout;
  logic [CW-1:0]  data_q;
  logic [1:0]     cout_q;
  logic [IDW-1:0] id_q;

  // Round-robin: scan from last_q+1 upward, wrapping; first valid wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_q) + k) % NREQ);
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign rsp_valid_o = (state_q == ST_FULL);
  assign slot_free   = (state_q == ST_EMPTY) | (rsp_valid_o & rsp_ready_i);
  // rst_ni gates the grant so nothing looks accepted while reset is held.
  assign accept      = win_found & slot_free & rst_ni;
  assign req_ready_o = accept ? (NREQ'(1) << win_idx) : '0;

  assign op_a = req_a_i[win_idx*CW +: CW];
  assign op_b = req_b_i[win_idx*CW +: CW];

  cadd_share_arbiter_ksa u_ksa (
    .a_i    (op_a),
    .b_i    (op_b),
    .sum_o  (sum),
    .cout_o (cout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (rsp_ready_i && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_EMPTY;
    else         state_q <= state_d;
  end

  // Result slot only loads on accept, so it holds under backpressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      cout_q <= '0;
      id_q   <= '0;
      last_q <= IDW'(NREQ - 1);
    end else if (accept) begin
      data_q <= sum;
      cout_q <= cout;
      id_q   <= win_idx;
      last_q <= win_idx;
    end
  end

  assign rsp_data_o = data_q;
  assign rsp_cout_o = cout_q;
  assign rsp_id_o   = id_q;

`ifdef CADD_ARB_GNT_CNT_EN
  logic [NREQ-1:0][CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (req_ready_o[i]) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
    end
  end

  assign gnt_cnt_o = cnt_q;
`else
  assign gnt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cadd_share_arbiter.sv
// Directed bench for cadd_share_arbiter (NREQ=4).
module tb_cadd_share_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*32-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic [1:0]        rsp_cout;
  logic [1:0]        rsp_id;
  logic [NREQ*16-1:0] gnt_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cadd_share_arbiter #(.NREQ(NREQ)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_cout_o  (rsp_cout),
    .rsp_id_o    (rsp_id),
    .gnt_cnt_o   (gnt_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++)
      set_op(i, {16'(i + 1), 16'(i + 1)}, 32'h0100_0010);

    // Reset state, with all requesters valid.
    #3;
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_data",  64'(rsp_data),  64'd0);
    chk("rst_cout",  64'(rsp_cout),  64'd0);
    chk("rst_id",    64'(rsp_id),    64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_cnt",   64'(gnt_cnt),   64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Round robin 0,1,2,3,0 with one result per cycle.
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_ready%0d", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
      tick();
      chk($sformatf("rr_valid%0d", k), 64'(rsp_valid), 64'd1);
      chk($sformatf("rr_id%0d", k),    64'(rsp_id),    64'(k % 4));
      chk($sformatf("rr_data%0d", k),  64'(rsp_data),
          64'({16'(16'h0101 + k % 4), 16'(16'h0011 + k % 4)}));
    end

    // Backpressure: result from requester 0 held for 3 cycles.
    rsp_ready = 1'b0;
    #1;
    chk("bp_ready0", 64'(req_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp_valid%0d", k), 64'(rsp_valid), 64'd1);
      chk($sformatf("bp_id%0d", k),    64'(rsp_id),    64'd0);
      chk($sformatf("bp_data%0d", k),  64'(rsp_data),  64'h0101_0011);
      chk($sformatf("bp_ready%0d", k), 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(req_ready), 64'b0010);
    tick();
    chk("bp_next_id",   64'(rsp_id),   64'd1);
    chk("bp_next_data", 64'(rsp_data), 64'h0102_0012);
    req_valid = '0;
    #1;
    chk("idle_ready", 64'(req_ready), 64'd0);
    tick();
    chk("drain_valid", 64'(rsp_valid), 64'd0);

    // Single request.
    set_op(0, 32'h0003_0005, 32'h0004_FFFF);
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    chk("single_valid", 64'(rsp_valid), 64'd1);
    chk("single_data",  64'(rsp_data),  64'h0007_0004);
    chk("single_cout",  64'(rsp_cout),  64'b01);
    chk("single_id",    64'(rsp_id),    64'd0);

    // Lane wrap in both lanes.
    set_op(0, 32'hFFFF_8000, 32'h0001_8000);
    req_valid = 4'b0001;
    #1;
    chk("wrap_ready", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    chk("wrap_data", 64'(rsp_data), 64'h0000_0000);
    chk("wrap_cout", 64'(rsp_cout), 64'b11);
    tick();
    chk("wrap_drain", 64'(rsp_valid), 64'd0);

    // Reset while FULL and stalled.
    set_op(2, 32'h0001_0001, 32'h0002_0002);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    #1;
    tick();
    req_valid = '0;
    chk("mid_valid", 64'(rsp_valid), 64'd1);
    chk("mid_id",    64'(rsp_id),    64'd2);
    chk("mid_data",  64'(rsp_data),  64'h0003_0003);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(rsp_valid), 64'd0);
    chk("arst_data",  64'(rsp_data),  64'd0);
    chk("arst_id",    64'(rsp_id),    64'd0);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    chk("arst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'b0001);
    tick();
    chk("post_rst_id",    64'(rsp_id),    64'd0);
    chk("post_rst_valid", 64'(rsp_valid), 64'd1);
    req_valid = '0;
    tick();

`ifdef CADD_ARB_GNT_CNT_EN
    rst_n = 1'b0;
    #1;
    chk("cnt_rst", 64'(gnt_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b0100;
    @(posedge clk);
    #1;
    for (int k = 1; k < 65537; k++) @(posedge clk);
    #1;
    req_valid = '0;
    chk("cnt_wrap2", 64'(gnt_cnt[47:32]), 64'd1);
    chk("cnt_other", 64'({gnt_cnt[63:48], gnt_cnt[31:0]}), 64'd0);
`else
    chk("cnt_tied", 64'(gnt_cnt), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cadd_share_arbiter.md
CADD_SHARE_ARBITER -- requirements
Module: cadd_share_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (legal range 2..8).
REQ-002 SHALL have localparam IDW = clog2(NREQ), the requester-ID width.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 REQ_VALID  input  NREQ  per-requester operand-valid.
REQ-006 REQ_A  input  NREQ*32  packed operand A per requester; slice i = [32i+31:32i], real [31:16], imag [15:0].
REQ-007 REQ_B  input  NREQ*32  packed operand B per requester, same layout.
REQ-008 REQ_READY  output  NREQ  one-hot grant; operand i is consumed when REQ_VALID[i] & REQ_READY[i].
REQ-009 RSP_VALID  output  1  result-valid.
REQ-010 RSP_READY  input  1  downstream accept.
REQ-011 RSP_DATA  output  32  complex sum {real, imag}.
REQ-012 RSP_COUT  output  2  {real carry, imag carry}.
REQ-013 RSP_ID  output  IDW  index of the requester that produced the result.
REQ-014 GNT_CNT  output  NREQ*16  per-requester grant counters (see Configuration).

Function
REQ-015 SHALL share one complex adder instance between all requesters; the adder operates on 16-bit real/imag lanes, modulo 2^16 per lane, carry-in 0, with no cross-lane carry.
REQ-016 SHALL use a two-state FSM: EMPTY (no result held) and FULL (result held, RSP_VALID=1).
REQ-017 SHALL define slot_free = (state==EMPTY) | (RSP_VALID & RSP_READY).
REQ-018 SHALL assert REQ_READY[i] only when slot_free and i is the round-robin winner among asserted REQ_VALID bits; at most one bit of REQ_READY set; REQ_READY all-zero when no valid or no slot.
REQ-019 Round-robin SHALL search from index (last_grant+1) mod NREQ upward, wrapping; last_grant updates only on an accepted transfer.
REQ-020 On accept of requester i, SHALL register sum, carries and ID=i next cycle; latency 1 cycle from accept edge to RSP_VALID=1.
REQ-021 EMPTY->FULL on accept; FULL->EMPTY on RSP_VALID&RSP_READY with no accept; FULL->FULL with new data when both occur in the same cycle (full throughput, 1 result/cycle).
REQ-022 In FULL with RSP_READY=0, RSP_DATA, RSP_COUT and RSP_ID SHALL hold stable.
REQ-023 SHALL never drop or duplicate an accepted operand; a requester not granted keeps its operands, and the arbiter does not require them stable.
REQ-024 REQ_READY is combinational from REQ_VALID, state and RSP_READY; requesters SHALL NOT derive REQ_VALID from REQ_READY.

Reset
REQ-025 RST_N low SHALL asynchronously force: state EMPTY, RSP_VALID 0, RSP_DATA 0, RSP_COUT 0, RSP_ID 0, last_grant NREQ-1 (so requester 0 wins first), and GNT_CNT 0.
REQ-026 Reset mid-transfer SHALL discard any held result; REQ_READY SHALL be 0 while RST_N is low.
REQ-027 Reset release SHALL be synchronised externally; the first grant is possible on the first edge after deassertion.

Configuration
REQ-028 Macro CADD_ARB_GNT_CNT_EN defined: one 16-bit counter per requester, incremented on each accepted transfer of that requester, wrapping 0xFFFF->0x0000, exposed on GNT_CNT slice [16i+15:16i].
REQ-029 Macro undefined: no counter flops; GNT_CNT tied to 0; all other behaviour identical.

Structure
REQ-030 A shared package SHALL hold the complex word width (32), the lane width (16), and the real/imag slice positions.
REQ-031 The sole sub-module SHALL be the existing 32-bit complex KSA adder, instantiated once and fed by the winner's operand mux.
REQ-032 The arbiter, mux, FSM and counters SHALL reside in this module; no extra pipeline stage.

Verification
REQ-033 Single request: REQ_VALID=0001, A=0x0003_0005, B=0x0004_FFFF, RSP_READY=1 -> next cycle RSP_VALID=1, DATA=0x0007_0004, COUT=01, ID=0.
REQ-034 All four valid continuously, RSP_READY=1 -> grants 0,1,2,3,0 on consecutive cycles; one RSP per cycle; IDs in the same order.
REQ-035 Backpressure: RSP_READY=0 for 3 cycles while FULL -> REQ_READY=0000, RSP outputs stable; RSP_READY=1 -> the held result is accepted and the next grant issues in the same cycle.
REQ-036 Lane wrap: A=0xFFFF_8000, B=0x0001_8000 -> DATA=0x0000_0000, COUT=11.
REQ-037 Reset asserted while FULL with RSP_READY=0 -> RSP_VALID drops immediately (async); after release, the first grant goes to requester 0.
REQ-038 With CADD_ARB_GNT_CNT_EN defined, 65537 grants to requester 2 -> GNT_CNT slice 2 = 1; with the macro undefined -> GNT_CNT = 0.
